versatile_mem_ctrl_fifo_sched: RTL and testbench
================================================

// Module: versatile_mem_ctrl_fifo_sched
// PURPOSE
//  SDRAM-clock-domain scheduler for the multi-queue egress/ingress FIFO pair between the wishbone ports and the SDRAM core.
//  Round-robin picks a non-empty egress queue, pops its address word and decodes WE/CTI/BTE.
//  For writes it buffers the burst data, then issues one command to the SDRAM core.
//  For reads it routes the returned beats into the matching ingress queue.
// PARAMETERS
//  nr_of_wb_ports  3  number of queues/ports (1..8)
//  port_w          2  width of port index, >= clog2(nr_of_wb_ports)
// PORTS
//  sdram_clk     in   1       single clock (SDRAM domain)
//  sdram_rst     in   1       asynchronous, active-high reset
//  fifo_empty    in   [0:N-1] egress queue empty flags
//  fifo_dat_i    in   36      egress q; valid the cycle after a pop
//  fifo_re       out  [0:N-1] one-hot egress queue select, pulsed with a pop
//  fifo_rd_adr   out  1       pop the address word
//  fifo_rd_data  out  1       pop a data word
//  ingress_full  in   [0:N-1] ingress queue full flags
//  fifo_wr       out  1       ingress write strobe
//  fifo_we       out  [0:N-1] one-hot ingress queue select
//  fifo_dat_o    out  32      ingress write data
//  cmd_valid     out  1       command request; held until cmd_ready
//  cmd_ready     in   1       SDRAM core accepts the command
//  cmd_we        out  1       1 = write burst
//  cmd_adr       out  30      start address, adr word [35:6]
//  cmd_bte       out  2       burst wrap type passed through
//  cmd_len       out  5       beats, 1/4/8/16
//  cmd_port      out  port_w  granted port index
//  wr_req        in   1       core requests the next write beat
//  wr_valid      out  1       write beat valid on wr_dat (1 cycle after wr_req)
//  wr_dat        out  32      write beat data
//  rd_valid      in   1       core read beat valid
//  rd_dat        in   32      core read beat data
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = N-1, so port 0 has first priority.
//  Address word format: [35:6] address, [5] WE, [4:3] BTE, [2:0] CTI.
//  len: 1 if CTI==000, CTI==111 or BTE==00. Otherwise BTE 01 gives 4, 10 gives 8, 11 gives 16.
//  FSM:
//   IDLE: grant = first i with !fifo_empty[i], searching from ptr+1 mod N upward. If none, stay.
//   ADR: one-cycle pulse of fifo_rd_adr and fifo_re[grant].
//   DEC: capture fifo_dat_i into adr_r; compute len and we. Go to WFILL if WE, else CMD.
//   WFILL: pop data with fifo_rd_data and fifo_re[grant] while popped<len and !fifo_empty[grant].
//    Pops may be back-to-back; each popped word is stored into buf[cap] the next cycle.
//    Go to CMD when cap==len.
//   CMD: cmd_valid=1 with stable cmd_* fields; hold until the cmd_ready handshake.
//    Read bursts wait in CMD with cmd_valid=0 while ingress_full[grant]. Then go to WDATA or RDATA.
//   WDATA: each wr_req gives wr_valid=1 and wr_dat=buf[rptr] next cycle. wr_req beyond len is ignored.
//    After the len-th beat: ptr<=grant, go to IDLE.
//   RDATA: each rd_valid gives fifo_wr=1, fifo_we=onehot(grant), fifo_dat_o=rd_dat next cycle (registered).
//    After len beats: ptr<=grant, go to IDLE. rd_valid outside RDATA is ignored.
//  Ingress room for a granted burst is guaranteed by FIFO sizing; fifo_wr is never throttled.
//  fifo_re/fifo_we are always one-hot or zero; never asserted without rd_adr/rd_data/fifo_wr.
//  Reset mid-burst: immediate return to IDLE. Buffered data and the partial burst are discarded.
//  Counters are 5 bits (0..16); no wrap inside a burst.
//  cmd_ready while cmd_valid=0 is ignored.
// STRUCTURE
//  Shared include versatile_mem_ctrl_defines.v:
//   CTI/BTE codes (classic, endofburst, linear, wrap4/8/16).
//   Address word field positions.
//   Scheduler state encoding.
//  Sub-module versatile_mem_ctrl_rr_arb: N-way round-robin; inputs req vector and ptr; outputs one-hot grant and index.
//  Write buffer: 16x32 register array inside this module.
// TESTING
//  1. Reset, all queues empty -> no pops, cmd_valid=0, all outputs 0.
//  2. Port1 classic read at 0x100:
//   rd_adr pulse with fifo_re=010; cmd we=0, adr=0x100>>6 field, len=1.
//   One rd_valid 0xCAFEF00D -> fifo_wr, fifo_we=010, fifo_dat_o=0xCAFEF00D.
//  3. Port0 wrap4 write, data words 1..4 arriving with gaps:
//   4 rd_data pops, then cmd len=4.
//   wr_req x4 -> wr_dat 1,2,3,4, each 1 cycle after its wr_req.
//  4. All 3 queues non-empty continuously -> grants in order 0,1,2,0; no port serviced twice in a row.
//  5. Read granted with ingress_full[2]=1 -> cmd_valid held 0 until the flag clears. cmd_ready held low 5 cycles -> cmd fields stable.
//  6. Assert sdram_rst during WDATA beat 2 of 8 -> outputs 0 immediately. Next burst from a fresh address pop is serviced correctly.

Source files
------------

// File: rtl/versatile_mem_ctrl_fifo_sched_pkg.sv
// Shared definitions for the SDRAM-side FIFO scheduler: wishbone burst codes,
// egress address word layout, scheduler states and the burst length decode.
package versatile_mem_ctrl_fifo_sched_pkg;

    // Wishbone cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Wishbone burst type extensions
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Address word field positions
    localparam int ADR_HI = 35;
    localparam int ADR_LO = 6;
    localparam int WE_BIT = 5;
    localparam int BTE_HI = 4;
    localparam int BTE_LO = 3;
    localparam int CTI_HI = 2;
    localparam int CTI_LO = 0;

    localparam int BUF_DEPTH = 16;

    // Packed view of the 36-bit egress address word, MSB first
    typedef struct packed {
        logic [ADR_HI-ADR_LO:0] adr;
        logic                   we;
        logic [BTE_HI-BTE_LO:0] bte;
        logic [CTI_HI-CTI_LO:0] cti;
    } adr_word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADR,
        S_DEC,
        S_WFILL,
        S_CMD,
        S_WDATA,
        S_RDATA
    } sched_state_t;

    // Classic, end-of-burst and linear cycles are single beats; wrap bursts
    // take their length from BTE.
    function automatic logic [4:0] burst_len(input logic [2:0] cti, input logic [1:0] bte);
        if (cti == CTI_CLASSIC || cti == CTI_EOB || bte == BTE_LINEAR)
            return 5'd1;
        case (bte)
            BTE_WRAP4: return 5'd4;
            BTE_WRAP8: return 5'd8;
            default:   return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/versatile_mem_ctrl_rr_arb.sv
// N-way round-robin arbiter: grants the first requester above the pointer,
// wrapping modulo N. Pure combinational.
module versatile_mem_ctrl_rr_arb #(
    parameter int NR_PORTS = 3,
    parameter int PORT_W   = 2
) (
    input  logic [0:NR_PORTS-1] i_req,
    input  logic [PORT_W-1:0]   i_ptr,
    output logic [0:NR_PORTS-1] o_grant,
    output logic [PORT_W-1:0]   o_idx
);

    logic [PORT_W-1:0] w_j;
    logic              w_found;

    // Scan ptr+1, ptr+2, ... ptr+N (mod N) and take the first request
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        for (int k = 1; k <= NR_PORTS; k++) begin
            w_j = PORT_W'((int'(i_ptr) + k) % NR_PORTS);
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/versatile_mem_ctrl_fifo_sched.sv
// SDRAM-domain scheduler between the egress/ingress queue pair and the SDRAM
// core: picks a queue round-robin, decodes its address word, buffers write
// bursts, issues one command and steers read beats back to the right queue.
module versatile_mem_ctrl_fifo_sched
    import versatile_mem_ctrl_fifo_sched_pkg::*;
#(
    parameter int nr_of_wb_ports = 3,
    parameter int port_w         = 2
) (
    input  logic                      i_sdram_clk,
    input  logic                      i_sdram_rst,
    input  logic [0:nr_of_wb_ports-1] i_fifo_empty,
    input  logic [35:0]               i_fifo_dat,
    output logic [0:nr_of_wb_ports-1] o_fifo_re,
    output logic                      o_fifo_rd_adr,
    output logic                      o_fifo_rd_data,
    input  logic [0:nr_of_wb_ports-1] i_ingress_full,
    output logic                      o_fifo_wr,
    output logic [0:nr_of_wb_ports-1] o_fifo_we,
    output logic [31:0]               o_fifo_dat,
    output logic                      o_cmd_valid,
    input  logic                      i_cmd_ready,
    output logic                      o_cmd_we,
    output logic [29:0]               o_cmd_adr,
    output logic [1:0]                o_cmd_bte,
    output logic [4:0]                o_cmd_len,
    output logic [port_w-1:0]         o_cmd_port,
    input  logic                      i_wr_req,
    output logic                      o_wr_valid,
    output logic [31:0]               o_wr_dat,
    input  logic                      i_rd_valid,
    input  logic [31:0]               i_rd_dat
);

    sched_state_t                r_state, w_next;
    logic [port_w-1:0]           r_ptr, r_grant;
    logic [4:0]                  r_popped, r_cap, r_beats;
    logic                        r_pop_d;
    logic [31:0]                 r_buf [BUF_DEPTH];
    logic                        r_cmd_we;
    logic [29:0]                 r_cmd_adr;
    logic [1:0]                  r_cmd_bte;
    logic [4:0]                  r_cmd_len;
    logic [port_w-1:0]           r_cmd_port;
    logic                        r_wr_valid;
    logic [31:0]                 r_wr_dat;
    logic                        r_fifo_wr;
    logic [0:nr_of_wb_ports-1]   r_fifo_we;
    logic [31:0]                 r_fifo_dat;

    logic [0:nr_of_wb_ports-1]   w_req, w_arb_grant, w_grant_oh;
    logic [port_w-1:0]           w_arb_idx;
    logic                        w_arb_valid;
    adr_word_t                   w_dec;
    logic                        w_rd_adr, w_rd_data, w_cmd_valid, w_wbeat, w_rbeat;

    assign w_req       = ~i_fifo_empty;
    assign w_arb_valid = |w_arb_grant;
    assign w_dec       = adr_word_t'(i_fifo_dat);

    versatile_mem_ctrl_rr_arb #(
        .NR_PORTS (nr_of_wb_ports),
        .PORT_W   (port_w)
    ) u_arb (
        .i_req    (w_req),
        .i_ptr    (r_ptr),
        .o_grant  (w_arb_grant),
        .o_idx    (w_arb_idx)
    );

    // One-hot of the latched grant, used for both egress pops and ingress writes
    always_comb begin
        w_grant_oh          = '0;
        w_grant_oh[r_grant] = 1'b1;
    end

    // Next state and per-state strobes
    always_comb begin
        w_next      = r_state;
        w_rd_adr    = 1'b0;
        w_rd_data   = 1'b0;
        w_cmd_valid = 1'b0;
        w_wbeat     = 1'b0;
        w_rbeat     = 1'b0;
        case (r_state)
            S_IDLE:  if (w_arb_valid) w_next = S_ADR;
            S_ADR: begin
                w_rd_adr = 1'b1;
                w_next   = S_DEC;
            end
            S_DEC:   w_next = w_dec.we ? S_WFILL : S_CMD;
            S_WFILL: begin
                w_rd_data = (r_popped < r_cmd_len) && !i_fifo_empty[r_grant];
                if (r_cap == r_cmd_len) w_next = S_CMD;
            end
            S_CMD: begin
                // Reads wait for room in the target ingress queue before asking
                w_cmd_valid = r_cmd_we || !i_ingress_full[r_grant];
                if (w_cmd_valid && i_cmd_ready)
                    w_next = r_cmd_we ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                w_wbeat = i_wr_req && (r_beats < r_cmd_len);
                if (w_wbeat && (r_beats + 5'd1 == r_cmd_len)) w_next = S_IDLE;
            end
            S_RDATA: begin
                w_rbeat = i_rd_valid;
                if (w_rbeat && (r_beats + 5'd1 == r_cmd_len)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, burst bookkeeping and registered data-path outputs
    always_ff @(posedge i_sdram_clk or posedge i_sdram_rst) begin
        if (i_sdram_rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= port_w'(nr_of_wb_ports - 1);
            r_grant    <= '0;
            r_popped   <= '0;
            r_cap      <= '0;
            r_beats    <= '0;
            r_pop_d    <= 1'b0;
            r_cmd_we   <= 1'b0;
            r_cmd_adr  <= '0;
            r_cmd_bte  <= '0;
            r_cmd_len  <= '0;
            r_cmd_port <= '0;
            r_wr_valid <= 1'b0;
            r_wr_dat   <= '0;
            r_fifo_wr  <= 1'b0;
            r_fifo_we  <= '0;
            r_fifo_dat <= '0;
        end else begin
            r_state <= w_next;
            r_pop_d <= w_rd_data;
            case (r_state)
                S_IDLE: if (w_arb_valid) r_grant <= w_arb_idx;
                S_DEC: begin
                    r_cmd_we   <= w_dec.we;
                    r_cmd_adr  <= w_dec.adr;
                    r_cmd_bte  <= w_dec.bte;
                    r_cmd_len  <= burst_len(w_dec.cti, w_dec.bte);
                    r_cmd_port <= r_grant;
                    r_popped   <= '0;
                    r_cap      <= '0;
                    r_beats    <= '0;
                end
                S_WFILL: begin
                    if (w_rd_data) r_popped <= r_popped + 5'd1;
                    if (r_pop_d)   r_cap    <= r_cap + 5'd1;
                end
                S_WDATA, S_RDATA: begin
                    if (w_wbeat || w_rbeat) r_beats <= r_beats + 5'd1;
                    if (w_next == S_IDLE)   r_ptr   <= r_grant;
                end
                default: ;
            endcase
            r_wr_valid <= w_wbeat;
            if (w_wbeat) r_wr_dat <= r_buf[r_beats[3:0]];
            r_fifo_wr  <= w_rbeat;
            r_fifo_we  <= w_rbeat ? w_grant_oh : '0;
            if (w_rbeat) r_fifo_dat <= i_rd_dat;
        end
    end

    // Write burst buffer; a word lands here the cycle after its pop
    always_ff @(posedge i_sdram_clk) begin
        if (r_pop_d) r_buf[r_cap[3:0]] <= i_fifo_dat[31:0];
    end

    assign o_fifo_rd_adr  = w_rd_adr;
    assign o_fifo_rd_data = w_rd_data;
    assign o_fifo_re      = (w_rd_adr || w_rd_data) ? w_grant_oh : '0;
    assign o_cmd_valid    = w_cmd_valid;
    assign o_cmd_we       = r_cmd_we;
    assign o_cmd_adr      = r_cmd_adr;
    assign o_cmd_bte      = r_cmd_bte;
    assign o_cmd_len      = r_cmd_len;
    assign o_cmd_port     = r_cmd_port;
    assign o_wr_valid     = r_wr_valid;
    assign o_wr_dat       = r_wr_dat;
    assign o_fifo_wr      = r_fifo_wr;
    assign o_fifo_we      = r_fifo_we;
    assign o_fifo_dat     = r_fifo_dat;

endmodule

// File: tb/tb_versatile_mem_ctrl_fifo_sched.sv
// Directed bench for the SDRAM-side FIFO scheduler with a small egress queue model.
module tb_versatile_mem_ctrl_fifo_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:2]  fifo_empty;
    logic [35:0] fifo_dat = '0;
    logic [0:2]  fifo_re;
    logic        fifo_rd_adr, fifo_rd_data;
    logic [0:2]  ingress_full = '0;
    logic        fifo_wr;
    logic [0:2]  fifo_we;
    logic [31:0] fifo_dat_o;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        cmd_we;
    logic [29:0] cmd_adr;
    logic [1:0]  cmd_bte;
    logic [4:0]  cmd_len;
    logic [1:0]  cmd_port;
    logic        wr_req = 1'b0;
    logic        wr_valid;
    logic [31:0] wr_dat;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_dat = '0;

    int errors = 0;
    int checks = 0;
    int viol   = 0;

    always #5 clk = ~clk;

    versatile_mem_ctrl_fifo_sched dut (
        .i_sdram_clk    (clk),
        .i_sdram_rst    (rst),
        .i_fifo_empty   (fifo_empty),
        .i_fifo_dat     (fifo_dat),
        .o_fifo_re      (fifo_re),
        .o_fifo_rd_adr  (fifo_rd_adr),
        .o_fifo_rd_data (fifo_rd_data),
        .i_ingress_full (ingress_full),
        .o_fifo_wr      (fifo_wr),
        .o_fifo_we      (fifo_we),
        .o_fifo_dat     (fifo_dat_o),
        .o_cmd_valid    (cmd_valid),
        .i_cmd_ready    (cmd_ready),
        .o_cmd_we       (cmd_we),
        .o_cmd_adr      (cmd_adr),
        .o_cmd_bte      (cmd_bte),
        .o_cmd_len      (cmd_len),
        .o_cmd_port     (cmd_port),
        .i_wr_req       (wr_req),
        .o_wr_valid     (wr_valid),
        .o_wr_dat       (wr_dat),
        .i_rd_valid     (rd_valid),
        .i_rd_dat       (rd_dat)
    );

    // Egress queue model: per-port storage, head advanced by pops, tail by pushes
    logic [35:0] mem [3][64];
    int          head [3];
    int          tail [3];

    always_comb begin
        fifo_empty = '0;
        for (int i = 0; i < 3; i++) fifo_empty[i] = (head[i] == tail[i]);
    end

    always @(posedge clk) begin : model
        int v;
        v = 0;
        for (int i = 0; i < 3; i++) begin
            if (fifo_re[i] && (fifo_rd_adr || fifo_rd_data)) begin
                if (head[i] == tail[i]) v++;
                else begin
                    fifo_dat <= mem[i][head[i]];
                    head[i]  <= head[i] + 1;
                end
            end
        end
        if ((fifo_rd_adr || fifo_rd_data) && $countones(fifo_re) != 1) v++;
        if (!(fifo_rd_adr || fifo_rd_data) && fifo_re != '0) v++;
        if (fifo_rd_adr && fifo_rd_data) v++;
        if (fifo_wr != ($countones(fifo_we) == 1)) v++;
        if ($countones(fifo_we) > 1) v++;
        viol <= viol + v;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:2] oh(input logic [1:0] p);
        logic [0:2] r;
        r    = '0;
        r[p] = 1'b1;
        return r;
    endfunction

    function automatic logic [35:0] mkw(input logic [29:0] a, input logic we,
                                        input logic [1:0] bte, input logic [2:0] cti);
        return {a, we, bte, cti};
    endfunction

    task automatic push(input int p, input logic [35:0] w);
        mem[p][tail[p]] = w;
        tail[p] = tail[p] + 1;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {fifo_rd_adr, fifo_rd_data, fifo_re, fifo_wr, fifo_we, fifo_dat_o,
                  cmd_valid, cmd_we, cmd_adr, cmd_bte, cmd_len, cmd_port, wr_valid, wr_dat}, '0);
    endtask

    task automatic wait_adr(input string tag, input logic [1:0] p);
        int n;
        n = 0;
        while (!fifo_rd_adr && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_adr_wait"}, n < 40, 1'b1);
        chk({tag, "_re"}, fifo_re, oh(p));
    endtask

    task automatic wait_cmd(input string tag, input logic we, input logic [29:0] a,
                            input logic [1:0] bte, input logic [4:0] len, input logic [1:0] p);
        int n;
        n = 0;
        while (!cmd_valid && n < 60) begin @(negedge clk); n++; end
        chk({tag, "_cmd_wait"}, n < 60, 1'b1);
        chk({tag, "_cmd"}, {cmd_we, cmd_adr, cmd_bte, cmd_len, cmd_port}, {we, a, bte, len, p});
    endtask

    task automatic handshake(input string tag);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        chk({tag, "_cmd_drop"}, cmd_valid, 1'b0);
    endtask

    task automatic do_rdata(input string tag, input logic [1:0] p, input int len, input logic [31:0] base);
        for (int k = 0; k < len; k++) begin
            rd_valid = 1'b1;
            rd_dat   = base + 32'(k);
            @(negedge clk);
            rd_valid = 1'b0;
            chk({tag, "_rbeat"}, {fifo_wr, fifo_we, fifo_dat_o}, {1'b1, oh(p), base + 32'(k)});
        end
        @(negedge clk);
        chk({tag, "_rdone"}, fifo_wr, 1'b0);
    endtask

    task automatic do_wdata(input string tag, input int len, input logic [31:0] base);
        for (int k = 0; k < len; k++) begin
            wr_req = 1'b1;
            @(negedge clk);
            wr_req = 1'b0;
            chk({tag, "_wbeat"}, {wr_valid, wr_dat}, {1'b1, base + 32'(k)});
            @(negedge clk);
            chk({tag, "_wgap"}, wr_valid, 1'b0);
        end
    endtask

    task automatic serve_read(input string tag, input logic [1:0] p, input logic [29:0] a,
                              input logic [1:0] bte, input logic [4:0] len, input logic [31:0] base);
        wait_adr(tag, p);
        wait_cmd(tag, 1'b0, a, bte, len, p);
        handshake(tag);
        do_rdata(tag, p, int'(len), base);
    endtask

    initial begin
        // 1: reset and idle with all queues empty
        repeat (2) @(negedge clk);
        chk_zero("t1_reset");
        rst = 1'b0;
        rd_valid  = 1'b1;
        cmd_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t1_idle", {fifo_rd_adr, fifo_rd_data, fifo_re, cmd_valid, fifo_wr}, '0);
        end
        rd_valid  = 1'b0;
        cmd_ready = 1'b0;

        // 2: port 1 classic read at byte address 0x100
        push(1, 36'h100);
        serve_read("t2", 2'd1, 30'h4, 2'b00, 5'd1, 32'hCAFEF00D);

        // 3: port 0 wrap4 write, data trickling in with gaps
        push(0, mkw(30'h123, 1'b1, 2'b01, 3'b010));
        wait_adr("t3", 2'd0);
        for (int k = 1; k <= 4; k++) begin
            repeat (2) begin
                @(negedge clk);
                chk("t3_nocmd", cmd_valid, 1'b0);
            end
            push(0, {4'h0, 32'(k)});
        end
        wait_cmd("t3", 1'b1, 30'h123, 2'b01, 5'd4, 2'd0);
        chk("t3_pops", 32'(head[0]), 32'd5);
        handshake("t3");
        do_wdata("t3", 4, 32'd1);
        wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        chk("t3_extra_req", wr_valid, 1'b0);

        // 4: fresh reset, all queues loaded -> grants 0,1,2,0
        rst = 1'b1;
        #1;
        chk_zero("t4_reset");
        @(negedge clk);
        rst = 1'b0;
        push(0, mkw(30'h10, 1'b0, 2'b00, 3'b000));
        push(0, mkw(30'h11, 1'b0, 2'b00, 3'b010));
        push(1, mkw(30'h20, 1'b0, 2'b10, 3'b010));
        push(1, mkw(30'h21, 1'b0, 2'b00, 3'b000));
        push(2, mkw(30'h30, 1'b0, 2'b11, 3'b111));
        push(2, mkw(30'h31, 1'b0, 2'b11, 3'b010));
        serve_read("t4a", 2'd0, 30'h10, 2'b00, 5'd1,  32'hA000_0000);
        serve_read("t4b", 2'd1, 30'h20, 2'b10, 5'd8,  32'hB000_0000);
        serve_read("t4c", 2'd2, 30'h30, 2'b11, 5'd1,  32'hC000_0000);
        serve_read("t4d", 2'd0, 30'h11, 2'b00, 5'd1,  32'hD000_0000);

        // 5: ingress full on port 2 blocks only port 2's command
        ingress_full = oh(2'd2);
        serve_read("t5a", 2'd1, 30'h21, 2'b00, 5'd1, 32'hE000_0000);
        wait_adr("t5b", 2'd2);
        repeat (6) begin
            @(negedge clk);
            chk("t5_blocked", cmd_valid, 1'b0);
        end
        ingress_full = '0;
        @(negedge clk);
        repeat (5) begin
            chk("t5_stable", {cmd_valid, cmd_we, cmd_adr, cmd_bte, cmd_len, cmd_port},
                {1'b1, 1'b0, 30'h31, 2'b11, 5'd16, 2'd2});
            @(negedge clk);
        end
        handshake("t5b");
        do_rdata("t5b", 2'd2, 16, 32'hF000_0000);

        // 6: reset in the middle of an 8-beat write, then a fresh burst
        push(0, mkw(30'h2AA, 1'b1, 2'b10, 3'b010));
        for (int k = 0; k < 8; k++) push(0, {4'h0, 32'h100 + 32'(k)});
        wait_adr("t6a", 2'd0);
        wait_cmd("t6a", 1'b1, 30'h2AA, 2'b10, 5'd8, 2'd0);
        handshake("t6a");
        wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        chk("t6_beat1", {wr_valid, wr_dat}, {1'b1, 32'h100});
        wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        chk("t6_beat2", {wr_valid, wr_dat}, {1'b1, 32'h101});
        rst = 1'b1;
        #1;
        chk_zero("t6_reset");
        @(negedge clk);
        rst = 1'b0;
        push(0, mkw(30'h055, 1'b1, 2'b01, 3'b010));
        for (int k = 0; k < 4; k++) push(0, {4'h0, 32'h200 + 32'(k)});
        wait_adr("t6b", 2'd0);
        wait_cmd("t6b", 1'b1, 30'h055, 2'b01, 5'd4, 2'd0);
        handshake("t6b");
        do_wdata("t6b", 4, 32'h200);

        chk("queue_protocol", 32'(viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
